// File: rtl/pipe_stall_ctrl_if.sv
// Stall-controller bundle: per-stage stall requests and EX/MEM status in, stall vector and status out.
// The controller connects through the slave modport; the pipeline side uses master.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned PERF_W = 32
) ();
  logic              stallreq_if;
  logic              stallreq_id;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              mem_req;
  logic              mem_ack;
  logic              flush_req;
  logic [5:0]        stall;
  logic              flush;
  logic              ex_mc_done;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack, flush_req,
    input  stall, flush, ex_mc_done, mem_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, ex_mc_start, ex_mc_cycles, mem_req, mem_ack, flush_req,
    output stall, flush, ex_mc_done, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller with EX multi-cycle sequencer and MEM wait tracker.
// Define PIPE_MEM_TIMEOUT_EN to enable the MEM wait timeout (mem_timeout pulse after TIMEOUT cycles).
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned PERF_W  = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ExIdle, ExBusy, ExDone} ex_state_e;

  ex_state_e         ex_state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ex_done_q;
  logic [PERF_W-1:0] stall_cycles_q;
  logic              stallreq_mem;
  logic              stallreq_ex;
  logic              mem_timeout;
  logic [5:0]        stall;

  assign stallreq_mem = bus.mem_req & ~bus.mem_ack & ~mem_timeout;
  assign stallreq_ex  = ((ex_state_q == ExIdle) & bus.ex_mc_start & (bus.ex_mc_cycles != '0)) |
                        (ex_state_q == ExBusy);

  always_comb begin
    stall = 6'b000000;
    if (bus.flush_req)     stall = 6'b000000;
    else if (stallreq_mem) stall = 6'b011111;
    else if (stallreq_ex)  stall = 6'b001111;
    else if (bus.stallreq_id) stall = 6'b000111;
    else if (bus.stallreq_if) stall = 6'b000011;
  end

  // ex_done_q mirrors "state is ExDone" so the done pulse comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_req) begin
      ex_state_q <= ExIdle;
      cnt_q      <= '0;
      ex_done_q  <= 1'b0;
    end else begin
      ex_done_q <= 1'b0;
      unique case (ex_state_q)
        ExIdle: begin
          if (bus.ex_mc_start) begin
            if (bus.ex_mc_cycles == CNT_W'(1)) begin
              ex_state_q <= ExDone;
              ex_done_q  <= 1'b1;
            end else if (bus.ex_mc_cycles != '0) begin
              cnt_q      <= bus.ex_mc_cycles - CNT_W'(1);
              ex_state_q <= ExBusy;
            end
          end
        end
        ExBusy: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            ex_state_q <= ExDone;
            ex_done_q  <= 1'b1;
          end
        end
        ExDone: ex_state_q <= ExIdle;
        default: ex_state_q <= ExIdle;
      endcase
    end
  end

`ifdef PIPE_MEM_TIMEOUT_EN
  typedef enum logic {MIdle, MWait} mem_state_e;

  localparam int unsigned WcntW = $clog2(TIMEOUT + 1);

  mem_state_e       mem_state_q;
  logic [WcntW-1:0] wcnt_q;

  assign mem_timeout = (mem_state_q == MWait) & bus.mem_req & ~bus.mem_ack &
                       (wcnt_q == WcntW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || bus.flush_req) begin
      mem_state_q <= MIdle;
      wcnt_q      <= '0;
    end else begin
      unique case (mem_state_q)
        MIdle: begin
          if (bus.mem_req && !bus.mem_ack) begin
            mem_state_q <= MWait;
            wcnt_q      <= WcntW'(1);
          end
        end
        MWait: begin
          if (bus.mem_ack || !bus.mem_req || mem_timeout) begin
            mem_state_q <= MIdle;
            wcnt_q      <= '0;
          end else if (wcnt_q != '1) begin
            wcnt_q <= wcnt_q + WcntW'(1);
          end
        end
        default: mem_state_q <= MIdle;
      endcase
    end
  end
`else
  // Without the timeout a MEM wait simply stalls until the access completes.
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if ((stall != 6'b000000) && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + PERF_W'(1);
    end
  end

  assign bus.stall        = stall;
  assign bus.flush        = bus.flush_req;
  assign bus.ex_mc_done   = ex_done_q;
  assign bus.mem_timeout  = mem_timeout;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: literal vector table, hand-written corner sequences and a random
// phase, all also checked against a cycle-count reference model.
module tb_pipe_stall_ctrl;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned PERF_W  = 8;
  localparam int          SAT     = (1 << PERF_W) - 1;
`ifdef PIPE_MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    bit r, sif, sid, st;
    int n;
    bit rq, ak, fl;
    int e_stall;   // -1 = not checked literally
    int e_done;
    int e_to;
    int e_scyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .PERF_W(PERF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining stall cycles of the EX op, done-pulse flag, consecutive MEM
  // wait cycles since the last clear, and the stall-cycle count.
  int m_left = 0;
  bit m_done = 1'b0;
  int m_run  = 0;
  int m_scyc = 0;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit sif, bit sid, bit st, int n, bit rq, bit ak, bit fl,
                              int es, int ed, int et, int esc);
    vec_t v;
    v.r = r; v.sif = sif; v.sid = sid; v.st = st; v.n = n;
    v.rq = rq; v.ak = ak; v.fl = fl;
    v.e_stall = es; v.e_done = ed; v.e_to = et; v.e_scyc = esc;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag);
    bit   ex_stall, wait_c, x_to;
    int   x_stall;
    rst              = v.r;
    bus.stallreq_if  = v.sif;
    bus.stallreq_id  = v.sid;
    bus.ex_mc_start  = v.st;
    bus.ex_mc_cycles = CNT_W'(v.n);
    bus.mem_req      = v.rq;
    bus.mem_ack      = v.ak;
    bus.flush_req    = v.fl;
    #1;
    ex_stall = (m_left > 0) || (!m_done && v.st && v.n != 0);
    wait_c   = v.rq && !v.ak;
    x_to     = TO_EN && wait_c && (m_run == TIMEOUT);
    if (v.fl)                x_stall = 6'b000000;
    else if (wait_c && !x_to) x_stall = 6'b011111;
    else if (ex_stall)       x_stall = 6'b001111;
    else if (v.sid)          x_stall = 6'b000111;
    else if (v.sif)          x_stall = 6'b000011;
    else                     x_stall = 6'b000000;
    chk({tag, " model stall"}, 32'(bus.stall), 32'(x_stall));
    chk({tag, " model flush"}, 32'(bus.flush), 32'(v.fl));
    chk({tag, " model done"}, 32'(bus.ex_mc_done), 32'(m_done));
    chk({tag, " model timeout"}, 32'(bus.mem_timeout), 32'(x_to));
    chk({tag, " model stall_cycles"}, 32'(bus.stall_cycles), 32'(m_scyc));
    if (v.e_stall >= 0) chk({tag, " stall"}, 32'(bus.stall), 32'(v.e_stall));
    if (v.e_done >= 0)  chk({tag, " done"}, 32'(bus.ex_mc_done), 32'(v.e_done));
    if (v.e_to >= 0)    chk({tag, " timeout"}, 32'(bus.mem_timeout), 32'(v.e_to));
    if (v.e_scyc >= 0)  chk({tag, " stall_cycles"}, 32'(bus.stall_cycles), 32'(v.e_scyc));
    @(posedge clk);
    if (v.r) begin
      m_left = 0; m_done = 1'b0; m_run = 0; m_scyc = 0;
    end else begin
      if (x_stall != 0 && m_scyc != SAT) m_scyc++;
      if (v.fl) begin
        m_left = 0; m_done = 1'b0; m_run = 0;
      end else begin
        if (m_done) m_done = 1'b0;
        else if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end else if (v.st && v.n != 0) begin
          m_left = v.n - 1;
          if (m_left == 0) m_done = 1'b1;
        end
        if (x_to || !wait_c) m_run = 0;
        else m_run++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int burst;
    vec_t v;
    rst = 1'b1;
    bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0; bus.ex_mc_start = 1'b0;
    bus.ex_mc_cycles = '0; bus.mem_req = 1'b0; bus.mem_ack = 1'b0; bus.flush_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    //                r sif sid st n  rq ak fl  stall      done to scyc
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 1, 5, 0, 0, 0, 6'b001111, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 2);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 3);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 4);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 5);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 6);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 6);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 0, 0, 6);
    tbl[12] = mk(0, 0, 0, 1, 1, 0, 0, 0, 6'b001111, 0, 0, 6);
    tbl[13] = mk(0, 0, 0, 1, 3, 0, 0, 0, 6'b000000, 1, 0, 7);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 7);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0, 6'b000011, 0, 0, 7);
    tbl[16] = mk(0, 1, 1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 8);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 9);
    tbl[18] = mk(0, 0, 0, 1, 2, 1, 0, 0, 6'b011111, 0, 0, 9);
    tbl[19] = mk(0, 0, 0, 0, 0, 1, 1, 0, 6'b001111, 0, 0, 10);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 11);
    tbl[21] = mk(0, 1, 1, 0, 0, 1, 0, 1, 6'b000000, 0, -1, 11);
    for (int i = 0; i < 22; i++) step(tbl[i], $sformatf("vec%0d", i));

    // EX op keeps counting under a MEM stall; done still lands 6 cycles after start.
    step(mk(0, 0, 0, 1, 6, 0, 0, 0, 6'b001111, 0, 0, -1), "mc_mem0");
    for (int i = 1; i <= 3; i++)
      step(mk(0, 0, 0, 0, 0, 1, 0, 0, 6'b011111, 0, -1, -1), $sformatf("mc_mem%0d", i));
    step(mk(0, 0, 0, 0, 0, 1, 1, 0, 6'b001111, 0, 0, -1), "mc_mem4");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, -1), "mc_mem5");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, -1), "mc_mem6");

    // Flush mid-op aborts it with no done pulse afterwards.
    step(mk(0, 0, 0, 1, 4, 0, 0, 0, 6'b001111, 0, 0, -1), "flush0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, -1), "flush1");
    step(mk(0, 0, 1, 0, 0, 0, 0, 1, 6'b000000, 0, 0, -1), "flush2");
    for (int i = 3; i <= 6; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, -1), $sformatf("flush%0d", i));

    // MEM wait held with no ack.
    for (int i = 0; i < 7; i++) begin
      if (TO_EN && i == TIMEOUT)
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 6'b000000, 0, 1, -1), $sformatf("mwait%0d", i));
      else
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 6'b011111, 0, 0, -1), $sformatf("mwait%0d", i));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, -1), "mwait_end");

    // Random phase against the model only.
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      if (burst == 0 && $urandom_range(0, 5) == 0) burst = $urandom_range(1, 8);
      v = mk(($urandom_range(0, 149) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6),
             (burst > 0), (burst == 1), ($urandom_range(0, 39) == 0), -1, -1, -1, -1);
      step(v, $sformatf("rnd%0d", i));
      if (burst > 0) burst--;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
